// File: rtl/wb_decode_mux.sv
// wb_decode_mux: Wishbone slave-side address decoder and response mux with wait states, timeout and error response
module wb_decode_mux #(
  parameter int NSLV = 2,
  parameter logic [NSLV*12-1:0] BASE = {12'h380, 12'h300},
  parameter logic [NSLV*4-1:0] LAT = {4'd1, 4'd0},
  parameter int TIMEOUT = 255
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  input  logic                 wbs_stb_i,
  input  logic                 wbs_cyc_i,
  input  logic                 wbs_we_i,
  input  logic [3:0]           wbs_sel_i,
  input  logic [31:0]          wbs_adr_i,
  input  logic [31:0]          wbs_dat_i,
  output logic                 wbs_ack_o,
  output logic [31:0]          wbs_dat_o,
  output logic [NSLV-1:0]      s_stb_o,
  output logic [NSLV-1:0]      s_cyc_o,
  output logic                 s_we_o,
  output logic [3:0]           s_wmask_o,
  output logic [31:0]          s_adr_o,
  output logic [31:0]          s_dat_o,
  input  logic [NSLV-1:0]      s_ack_i,
  input  logic [NSLV*32-1:0]   s_dat_i,
  output logic                 err_o,
  output logic [7:0]           err_cnt_o,
  output logic                 busy_o
);
  typedef enum logic [1:0] {IDLE, ACTIVE, ACK, ERR} state_t;
  state_t state;
  logic [2:0] idx, dec_idx;
  logic hit, dec_hit, sel, done, s_ack_k;
  logic [3:0] wcnt, lat_k;
  logic [9:0] tcnt;
  logic [31:0] rdat_k;
  // lowest-index base match wins, so scan downward and let lower k overwrite
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int k = NSLV - 1; k >= 0; k--)
      if (wbs_adr_i[31:20] == BASE[12*k +: 12]) begin
        dec_hit = 1'b1;
        dec_idx = 3'(k);
      end
  end
  // view of the latched slave: its latency, ack, read data and strobe fan-out
  always_comb begin
    lat_k = '0;
    s_ack_k = 1'b0;
    rdat_k = '0;
    s_stb_o = '0;
    s_cyc_o = '0;
    for (int k = 0; k < NSLV; k++)
      if (idx == 3'(k)) begin
        lat_k = LAT[4*k +: 4];
        s_ack_k = s_ack_i[k];
        rdat_k = s_dat_i[32*k +: 32];
        s_stb_o[k] = sel & wbs_stb_i & wbs_cyc_i;
        s_cyc_o[k] = sel & wbs_cyc_i;
      end
  end
  assign sel = state == ACTIVE && hit;
  assign done = lat_k == 4'd0 ? s_ack_k : wcnt == lat_k - 4'd1;
  assign busy_o = state != IDLE;
  assign s_we_o = sel & wbs_we_i;
  assign s_wmask_o = sel ? wbs_sel_i & {4{wbs_we_i}} : 4'h0;
  assign s_adr_o = sel ? wbs_adr_i : 32'h0;
  assign s_dat_o = sel ? wbs_dat_i : 32'h0;
  // transaction FSM; a decode miss spends its one ACTIVE cycle with no slave strobed, then errors
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) begin
      state <= IDLE;
      idx <= '0;
      hit <= 1'b0;
      wcnt <= '0;
      tcnt <= '0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      err_o <= 1'b0;
      err_cnt_o <= '0;
    end else begin
      wbs_ack_o <= 1'b0;
      err_o <= 1'b0;
      case (state)
        IDLE: begin
          wcnt <= '0;
          tcnt <= '0;
          if (wbs_cyc_i && wbs_stb_i) begin
            state <= ACTIVE;
            idx <= dec_idx;
            hit <= dec_hit;
          end
        end
        ACTIVE:
          if (!wbs_cyc_i) state <= IDLE;
          else if (hit && done) begin
            state <= ACK;
            wbs_ack_o <= 1'b1;
            wbs_dat_o <= rdat_k;
          end else if (!hit || tcnt == 10'(TIMEOUT - 1)) begin
            state <= ERR;
            wbs_ack_o <= 1'b1;
            err_o <= 1'b1;
            wbs_dat_o <= 32'hDEAD_BEEF;
            err_cnt_o <= err_cnt_o + 8'(err_cnt_o != 8'hFF);
          end else begin
            wcnt <= wcnt + 4'd1;
            tcnt <= tcnt + 10'd1;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_wb_decode_mux.sv
// tb_wb_decode_mux: vector table, hand sequences and randomized model check for wb_decode_mux
module tb_wb_decode_mux;
  localparam int TO = 8;
  logic wb_clk_i = 1'b0, wb_rst_ni = 1'b1;
  logic wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0] wbs_sel_i = '0;
  logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
  logic wbs_ack_o, s_we_o, err_o, busy_o;
  logic [31:0] wbs_dat_o, s_adr_o, s_dat_o;
  logic [1:0] s_stb_o, s_cyc_o;
  logic [3:0] s_wmask_o;
  logic [1:0] s_ack_i = '0;
  logic [63:0] s_dat_i = '0;
  logic [7:0] err_cnt_o;
  int n_cmp = 0, n_fail = 0, errs = 0;

  wb_decode_mux #(.TIMEOUT(TO)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_we_o(s_we_o), .s_wmask_o(s_wmask_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
    .err_o(err_o), .err_cnt_o(err_cnt_o), .busy_o(busy_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // expected response from the address map: slave0 @0x300 LAT0, slave1 @0x380 LAT1
  function automatic void model(input logic [31:0] adr, input logic we, input logic [3:0] sel,
      input logic [31:0] d0, input logic [31:0] d1, input int dly,
      output logic [1:0] stb, output logic [3:0] wm, output logic [31:0] sadr,
      output int edge_n, output logic [31:0] dat, output logic err);
    logic [11:0] base [2];
    int lat [2];
    int k;
    base = '{12'h300, 12'h380};
    lat = '{0, 1};
    k = -1;
    for (int i = 1; i >= 0; i--) if (adr[31:20] == base[i]) k = i;
    stb = '0; wm = '0; sadr = '0; dat = 32'hDEAD_BEEF; err = 1'b1; edge_n = 2;
    if (k >= 0) begin
      stb = 2'(1 << k);
      wm = we ? sel : 4'h0;
      sadr = adr;
      dat = k == 1 ? d1 : d0;
      err = 1'b0;
      if (lat[k] > 0) edge_n = lat[k] + 1;
      else if (dly > 0) edge_n = dly + 1;
      else begin
        edge_n = TO + 1;
        err = 1'b1;
        dat = 32'hDEAD_BEEF;
      end
    end
  endfunction

  // one master transaction; slave 0 acks at edge dly+1 (never if dly==0); noise toggles ignored acks
  task automatic xact(input logic [31:0] adr, input logic we, input logic [3:0] sel, input logic [31:0] wdat,
      input logic [31:0] d0, input logic [31:0] d1, input int dly, input bit noise,
      output logic [1:0] stb, output logic [3:0] wm, output logic [31:0] sadr, output int edge_n,
      output logic [31:0] rdat, output logic err, output logic [7:0] cnt);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we; wbs_sel_i = sel;
    wbs_adr_i = adr; wbs_dat_i = wdat; s_dat_i = {d1, d0}; s_ack_i = '0;
    stb = '0; wm = '0; sadr = '0; edge_n = 0; rdat = '0; err = 1'b0; cnt = '0;
    for (int n = 1; n <= 40 && edge_n == 0; n++) begin
      s_ack_i[1] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      s_ack_i[0] = dly != 0 ? n == dly + 1 : noise && adr[31:20] != 12'h300 && $urandom_range(0, 1) == 1;
      tick();
      if (n == 1) begin
        stb = s_stb_o; wm = s_wmask_o; sadr = s_adr_o;
      end
      if (wbs_ack_o) begin
        edge_n = n; rdat = wbs_dat_o; err = err_o; cnt = err_cnt_o;
      end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; s_ack_i = '0;
    tick();
    chk("gap_ack", wbs_ack_o, 0);
    chk("gap_busy", busy_o, 0);
  endtask

  task automatic run_chk(input string tag, input logic [31:0] adr, input logic we, input logic [3:0] sel,
      input logic [31:0] wdat, input logic [31:0] d0, input logic [31:0] d1, input int dly, input bit noise);
    logic [1:0] es, gs;
    logic [3:0] ew, gw;
    logic [31:0] ea, ga, ed, gd;
    int ee, ge;
    logic er, gr;
    logic [7:0] gc;
    model(adr, we, sel, d0, d1, dly, es, ew, ea, ee, ed, er);
    xact(adr, we, sel, wdat, d0, d1, dly, noise, gs, gw, ga, ge, gd, gr, gc);
    if (er) errs++;
    chk({tag, "_stb"}, gs, es);
    chk({tag, "_wmask"}, gw, ew);
    chk({tag, "_sadr"}, ga, ea);
    chk({tag, "_ack_edge"}, ge, ee);
    chk({tag, "_dat"}, gd, ed);
    chk({tag, "_err"}, gr, er);
    chk({tag, "_cnt"}, gc, errs > 255 ? 255 : errs);
  endtask

  typedef struct {
    logic [31:0] adr; logic we; logic [3:0] sel; logic [31:0] wdat, d0, d1; int dly;
    logic [1:0] stb; logic [3:0] wm; logic [31:0] sadr; int edge_n; logic [31:0] dat; logic err; logic [7:0] cnt;
  } vec_t;

  initial begin
    vec_t vt [8];
    logic [1:0] gs;
    logic [3:0] gw;
    logic [31:0] ga, gd, adr;
    int ge, dly;
    logic gr;
    logic [7:0] gc;
    vt[0] = '{32'h3800_0010, 1'b0, 4'hF, 32'h0, 32'hA5A5_0000, 32'h1234_5678, 0, 2'b10, 4'h0, 32'h3800_0010, 2, 32'h1234_5678, 1'b0, 8'd0};
    vt[1] = '{32'h3000_0004, 1'b1, 4'hF, 32'hCAFE_0001, 32'h0BAD_F00D, 32'h1111_2222, 3, 2'b01, 4'hF, 32'h3000_0004, 4, 32'h0BAD_F00D, 1'b0, 8'd0};
    vt[2] = '{32'h2000_0000, 1'b0, 4'hF, 32'h0, 32'h1, 32'h2, 0, 2'b00, 4'h0, 32'h0, 2, 32'hDEAD_BEEF, 1'b1, 8'd1};
    vt[3] = '{32'h3000_0100, 1'b0, 4'hF, 32'h0, 32'h3, 32'h4, 0, 2'b01, 4'h0, 32'h3000_0100, TO + 1, 32'hDEAD_BEEF, 1'b1, 8'd2};
    vt[4] = '{32'h380F_FFFC, 1'b1, 4'h3, 32'h9999_0000, 32'h5, 32'h7777_8888, 0, 2'b10, 4'h3, 32'h380F_FFFC, 2, 32'h7777_8888, 1'b0, 8'd2};
    vt[5] = '{32'h3001_0000, 1'b0, 4'h1, 32'h0, 32'h5555_AAAA, 32'h6, 1, 2'b01, 4'h0, 32'h3001_0000, 2, 32'h5555_AAAA, 1'b0, 8'd2};
    vt[6] = '{32'h3810_0000, 1'b0, 4'hF, 32'h0, 32'h7, 32'h8, 0, 2'b00, 4'h0, 32'h0, 2, 32'hDEAD_BEEF, 1'b1, 8'd3};
    vt[7] = '{32'hFFF0_0000, 1'b1, 4'hF, 32'h1234, 32'h9, 32'hA, 0, 2'b00, 4'h0, 32'h0, 2, 32'hDEAD_BEEF, 1'b1, 8'd4};
    // reset state
    #2 wb_rst_ni = 1'b0;
    tick();
    tick();
    chk("rst_ack", wbs_ack_o, 0);
    chk("rst_dat", wbs_dat_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_cnt", err_cnt_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_stb", {s_stb_o, s_cyc_o}, 0);
    #3 wb_rst_ni = 1'b1;
    // vector table
    for (int i = 0; i < 8; i++) begin
      xact(vt[i].adr, vt[i].we, vt[i].sel, vt[i].wdat, vt[i].d0, vt[i].d1, vt[i].dly, 1'b0, gs, gw, ga, ge, gd, gr, gc);
      if (vt[i].err) errs++;
      chk($sformatf("vec%0d_stb", i), gs, vt[i].stb);
      chk($sformatf("vec%0d_wmask", i), gw, vt[i].wm);
      chk($sformatf("vec%0d_sadr", i), ga, vt[i].sadr);
      chk($sformatf("vec%0d_ack_edge", i), ge, vt[i].edge_n);
      chk($sformatf("vec%0d_dat", i), gd, vt[i].dat);
      chk($sformatf("vec%0d_err", i), gr, vt[i].err);
      chk($sformatf("vec%0d_cnt", i), gc, vt[i].cnt);
    end
    // abort: cyc dropped during ACTIVE
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h3000_0020; s_ack_i = '0;
    tick();
    chk("abort_stb_on", s_stb_o, 2'b01);
    chk("abort_cyc_on", s_cyc_o, 2'b01);
    wbs_cyc_i = 1'b0;
    #1;
    chk("abort_stb_gated", s_stb_o, 2'b00);
    chk("abort_cyc_gated", s_cyc_o, 2'b00);
    tick();
    wbs_stb_i = 1'b0;
    chk("abort_busy", busy_o, 0);
    chk("abort_ack", wbs_ack_o, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_quiet_ack", wbs_ack_o | err_o, 0);
    end
    run_chk("after_abort", 32'h3800_0300, 1'b0, 4'hF, 32'h0, 32'h1, 32'hBEEF_0042, 0, 1'b0);
    // asynchronous reset mid-ACTIVE
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_adr_i = 32'h3000_0000; s_ack_i = '0;
    tick();
    tick();
    chk("areset_busy_pre", busy_o, 1);
    chk("areset_stb_pre", s_stb_o, 2'b01);
    #2 wb_rst_ni = 1'b0;
    #1;
    chk("areset_busy", busy_o, 0);
    chk("areset_stb", {s_stb_o, s_cyc_o}, 0);
    chk("areset_sadr", s_adr_o, 0);
    chk("areset_ack", wbs_ack_o, 0);
    chk("areset_dat", wbs_dat_o, 0);
    chk("areset_cnt", err_cnt_o, 0);
    errs = 0;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    #3 wb_rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("areset_no_ack", {wbs_ack_o, busy_o}, 0);
    end
    // request pending across reset release is sampled on the first edge after release
    #2 wb_rst_ni = 1'b0;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_adr_i = 32'h3800_0040; s_dat_i = {32'h0F0F_1234, 32'h0};
    tick();
    chk("rel_hold_busy", busy_o, 0);
    #3 wb_rst_ni = 1'b1;
    tick();
    chk("rel_edge1_busy", busy_o, 1);
    chk("rel_edge1_ack", wbs_ack_o, 0);
    tick();
    chk("rel_edge2_ack", wbs_ack_o, 1);
    chk("rel_edge2_dat", wbs_dat_o, 32'h0F0F_1234);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    tick();
    chk("rel_single_ack", wbs_ack_o, 0);
    // randomized against the model, with ignored-ack noise
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: adr = {12'h300, 20'($urandom)};
        1: adr = {12'h380, 20'($urandom)};
        default: adr = $urandom;
      endcase
      dly = $urandom_range(0, 4) == 0 ? 0 : $urandom_range(1, 7);
      run_chk("rand", adr, 1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom, $urandom, dly, 1'b1);
    end
    // error counter saturation
    while (errs < 258) run_chk("sat", 32'h0000_0000 | 32'($urandom_range(0, 255)), 1'b0, 4'hF, 32'h0, 32'h0, 32'h0, 0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
